risc_v_mem_arbiter: RTL and testbench

//  Shares one single-ported unified memory between the RV32I core's instruction-fetch port and its load/store port.

---
 rtl/risc_v_mem_pkg.sv | 44 ++++
 rtl/risc_v_mem_lane.sv | 52 +++++
 rtl/risc_v_mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_risc_v_mem_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_v_mem_pkg.sv
// Shared types and helpers for the instruction/data memory arbiter.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
// Contents: arbiter state, access size, port owner, latched request context,
// and the size-alignment helpers used by the lane steering logic.
package risc_v_mem_pkg;

    typedef enum logic {ARB_IDLE, ARB_WAIT} arb_state_e;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2
    } mem_size_e;

    typedef enum logic {OWNER_IF, OWNER_D} arb_owner_e;

    // Everything the response path needs to remember about the access in flight.
    typedef struct packed {
        arb_owner_e owner;
        logic       we;
        logic [1:0] size;
        logic [1:0] off;
    } req_ctx_t;

    // Byte offset actually used: address bits below the size alignment are dropped.
    // Size 3 behaves as a word.
    function automatic logic [1:0] eff_offset(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SIZE_B:  return off;
            SIZE_H:  return {off[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SIZE_B:  return 1'b0;
            SIZE_H:  return off[0];
            default: return off != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/risc_v_mem_lane.sv
// Byte-lane steering: store byte enables / replicated write data, load data shifted to lane 0.
// Latency: purely combinational.
// Backpressure: none, no state.
// Ports: req_size_i/req_off_i/req_wdata_i -> be_o, wdata_o (request side);
//        rsp_size_i/rsp_off_i/rsp_rdata_i -> rsp_data_o (response side, zero-extended).
module risc_v_mem_lane
    import risc_v_mem_pkg::*;
(
    input  logic [1:0]  req_size_i,
    input  logic [1:0]  req_off_i,
    input  logic [31:0] req_wdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    input  logic [1:0]  rsp_size_i,
    input  logic [1:0]  rsp_off_i,
    input  logic [31:0] rsp_rdata_i,
    output logic [31:0] rsp_data_o
);

    logic [1:0]  req_eff;
    logic [1:0]  rsp_eff;
    logic [31:0] shifted;

    always_comb begin
        req_eff = eff_offset(req_size_i, req_off_i);
        be_o    = 4'hF;
        wdata_o = req_wdata_i;
        case (req_size_i)
            SIZE_B: begin
                be_o    = 4'b0001 << req_eff;
                wdata_o = {4{req_wdata_i[7:0]}};
            end
            SIZE_H: begin
                be_o    = 4'b0011 << req_eff;
                wdata_o = {2{req_wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        rsp_eff    = eff_offset(rsp_size_i, rsp_off_i);
        shifted    = rsp_rdata_i >> {rsp_eff, 3'b000};
        rsp_data_o = shifted;
        case (rsp_size_i)
            SIZE_B:  rsp_data_o = {24'b0, shifted[7:0]};
            SIZE_H:  rsp_data_o = {16'b0, shifted[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/risc_v_mem_arbiter.sv
// Shares one single-ported memory between the fetch port and the load/store port, one access in flight.
// Latency: request issued to memory the cycle it is accepted; response pulse one cycle after mem_rvalid_i.
// Backpressure: ready only in IDLE for the granted port; data wins unless fetch has waited STARVE_MAX data grants.
// Ports: clk_i, reset_i (sync, active-high); if_req_*/if_resp_* fetch port; d_req_*/d_resp_* load/store port;
//        mem_* single memory port (mem_rvalid_i completes every access, reads and writes).
// Optional feature: RISC_V_ARB_MISALIGN_CHECK_EN rejects misaligned accesses with an error response.
module risc_v_mem_arbiter
    import risc_v_mem_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            if_req_valid_i,
    output logic            if_req_ready_o,
    input  logic [XLEN-1:0] if_addr_i,
    output logic            if_resp_valid_o,
    output logic [XLEN-1:0] if_resp_data_o,
    input  logic            d_req_valid_i,
    output logic            d_req_ready_o,
    input  logic [XLEN-1:0] d_addr_i,
    input  logic            d_write_en_i,
    input  logic [1:0]      d_size_i,
    input  logic [XLEN-1:0] d_write_data_i,
    output logic            d_resp_valid_o,
    output logic [XLEN-1:0] d_resp_data_o,
    output logic            d_resp_err_o,
    output logic            mem_req_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic            mem_we_o,
    output logic [3:0]      mem_be_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic [XLEN-1:0] mem_rdata_i,
    input  logic            mem_rvalid_i
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    arb_state_e      state_q;
    logic [SW-1:0]   starve_q;
    req_ctx_t        ctx_q;
    logic            if_resp_valid_q;
    logic            d_resp_valid_q;
    logic            d_resp_err_q;
    logic [31:0]     resp_data_q;

    logic            grant_d;
    logic            grant_if;
    logic            req_mis;
    logic [1:0]      req_size;
    logic [31:0]     req_addr;
    logic [3:0]      lane_be;
    logic [31:0]     lane_wdata;
    logic [31:0]     lane_rdata;

    // Grants are suppressed while reset is held so nothing is accepted before the first clean cycle.
    always_comb begin
        grant_d  = 1'b0;
        grant_if = 1'b0;
        if (!reset_i && state_q == ARB_IDLE) begin
            if (d_req_valid_i && !(if_req_valid_i && starve_q == STARVE_LIM)) begin
                grant_d = 1'b1;
            end else if (if_req_valid_i) begin
                grant_if = 1'b1;
            end
        end
    end

    assign req_size = grant_d ? d_size_i : 2'(SIZE_W);
    assign req_addr = grant_d ? d_addr_i : if_addr_i;

`ifdef RISC_V_ARB_MISALIGN_CHECK_EN
    assign req_mis = (grant_d || grant_if) && misaligned(req_size, req_addr[1:0]);
`else
    assign req_mis = 1'b0;
`endif

    risc_v_mem_lane u_lane (
        .req_size_i  (d_size_i),
        .req_off_i   (d_addr_i[1:0]),
        .req_wdata_i (d_write_data_i),
        .be_o        (lane_be),
        .wdata_o     (lane_wdata),
        .rsp_size_i  (ctx_q.size),
        .rsp_off_i   (ctx_q.off),
        .rsp_rdata_i (mem_rdata_i),
        .rsp_data_o  (lane_rdata)
    );

    assign if_req_ready_o = grant_if;
    assign d_req_ready_o  = grant_d;

    // A rejected (misaligned) access is accepted but never reaches memory.
    assign mem_req_o   = (grant_d || grant_if) && !req_mis;
    assign mem_addr_o  = mem_req_o ? {req_addr[31:2], 2'b00} : 32'b0;
    assign mem_we_o    = mem_req_o && grant_d && d_write_en_i;
    assign mem_be_o    = mem_req_o ? (grant_d ? lane_be : 4'hF) : 4'h0;
    assign mem_wdata_o = (mem_req_o && grant_d) ? lane_wdata : 32'b0;

    assign if_resp_valid_o = if_resp_valid_q;
    assign d_resp_valid_o  = d_resp_valid_q;
    assign d_resp_err_o    = d_resp_err_q;
    assign if_resp_data_o  = resp_data_q;
    assign d_resp_data_o   = resp_data_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q         <= ARB_IDLE;
            starve_q        <= '0;
            ctx_q           <= '{owner: OWNER_IF, we: 1'b0, size: 2'b00, off: 2'b00};
            if_resp_valid_q <= 1'b0;
            d_resp_valid_q  <= 1'b0;
            d_resp_err_q    <= 1'b0;
            resp_data_q     <= 32'b0;
        end else begin
            if_resp_valid_q <= 1'b0;
            d_resp_valid_q  <= 1'b0;
            d_resp_err_q    <= 1'b0;

            // Counts data grants that overtook a waiting fetch.
            if (!if_req_valid_i || grant_if) begin
                starve_q <= '0;
            end else if (grant_d && starve_q != STARVE_LIM) begin
                starve_q <= starve_q + 1'b1;
            end

            case (state_q)
                ARB_IDLE: begin
                    if (grant_d || grant_if) begin
                        if (req_mis) begin
                            if_resp_valid_q <= grant_if;
                            d_resp_valid_q  <= grant_d;
                            d_resp_err_q    <= grant_d;
                            resp_data_q     <= 32'b0;
                        end else begin
                            state_q     <= ARB_WAIT;
                            ctx_q.owner <= grant_d ? OWNER_D : OWNER_IF;
                            ctx_q.we    <= grant_d && d_write_en_i;
                            ctx_q.size  <= req_size;
                            ctx_q.off   <= req_addr[1:0];
                        end
                    end
                end
                ARB_WAIT: begin
                    if (mem_rvalid_i) begin
                        state_q <= ARB_IDLE;
                        if (ctx_q.owner == OWNER_IF) begin
                            if_resp_valid_q <= 1'b1;
                            resp_data_q     <= mem_rdata_i;
                        end else begin
                            d_resp_valid_q <= 1'b1;
                            resp_data_q    <= ctx_q.we ? 32'b0 : lane_rdata;
                        end
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_risc_v_mem_arbiter.sv
// Self-checking bench for risc_v_mem_arbiter with a byte-array reference memory and a latency-programmable responder.
// Latency: n/a.
// Backpressure: n/a.
module tb_risc_v_mem_arbiter;

    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req_valid, if_req_ready, if_resp_valid;
    logic [31:0] if_addr, if_resp_data;
    logic        d_req_valid, d_req_ready, d_we, d_resp_valid, d_resp_err;
    logic [1:0]  d_size;
    logic [31:0] d_addr, d_wdata, d_resp_data;
    logic        mem_req, mem_we, mem_rvalid;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int tests_run = 0;
    int failed    = 0;
    int lat_fixed = 1;
    int pend      = 0;
    int rvalid_seen = 0;
    logic [31:0] rd_next;

    logic [7:0] phys_mem [0:1023];
    logic [7:0] ref_mem  [0:1023];

    risc_v_mem_arbiter #(.XLEN(32), .STARVE_MAX(STARVE_MAX)) dut (
        .clk_i           (clk),
        .reset_i         (reset),
        .if_req_valid_i  (if_req_valid),
        .if_req_ready_o  (if_req_ready),
        .if_addr_i       (if_addr),
        .if_resp_valid_o (if_resp_valid),
        .if_resp_data_o  (if_resp_data),
        .d_req_valid_i   (d_req_valid),
        .d_req_ready_o   (d_req_ready),
        .d_addr_i        (d_addr),
        .d_write_en_i    (d_we),
        .d_size_i        (d_size),
        .d_write_data_i  (d_wdata),
        .d_resp_valid_o  (d_resp_valid),
        .d_resp_data_o   (d_resp_data),
        .d_resp_err_o    (d_resp_err),
        .mem_req_o       (mem_req),
        .mem_addr_o      (mem_addr),
        .mem_we_o        (mem_we),
        .mem_be_o        (mem_be),
        .mem_wdata_o     (mem_wdata),
        .mem_rdata_i     (mem_rdata),
        .mem_rvalid_i    (mem_rvalid)
    );

    always #5 clk = ~clk;

    // Memory responder: completes every access lat_fixed cycles after the mem_req cycle.
    initial begin
        mem_rvalid = 1'b0;
        mem_rdata  = 32'b0;
        forever begin
            @(negedge clk);
            #2;
            mem_rvalid = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = rd_next;
                    rvalid_seen++;
                end
            end else if (mem_req) begin
                if (mem_we) begin
                    for (int i = 0; i < 4; i++)
                        if (mem_be[i]) phys_mem[int'(mem_addr[9:0]) + i] = mem_wdata[8*i +: 8];
                    rd_next = $urandom;
                end else begin
                    for (int i = 0; i < 4; i++) rd_next[8*i +: 8] = phys_mem[int'(mem_addr[9:0]) + i];
                end
                pend = lat_fixed;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (time %0t, limit 500000)", $time);
        $fatal(1);
    end

    // One access on either port, checked against the byte-level reference memory.
    task automatic do_access(input bit is_if, input logic [31:0] a, input logic we_in,
                             input logic [1:0] sz, input logic [31:0] wd, input string nm,
                             output logic [31:0] rdat);
        int nb, o, n, k;
        bit mis, we, got_v;
        logic [3:0]  ebe;
        logic [31:0] ewd, erd;
        logic [9:0]  base;
        logic [69:0] got_req, exp_req;
        logic [34:0] got_rsp, exp_rsp;
        we   = is_if ? 1'b0 : we_in;
        nb   = is_if ? 4 : (sz == 2'd0 ? 1 : (sz == 2'd1 ? 2 : 4));
        o    = (int'(a[1:0]) / nb) * nb;
        mis  = 1'b0;
`ifdef RISC_V_ARB_MISALIGN_CHECK_EN
        mis  = (int'(a[1:0]) % nb) != 0;
`endif
        base = {a[9:2], 2'b00};
        ebe  = 4'((1 << nb) - 1) << o;
        for (int i = 0; i < 4; i++) ewd[8*i +: 8] = wd[8*(i % nb) +: 8];
        erd = 32'b0;
        for (int i = 0; i < nb; i++) erd[8*i +: 8] = ref_mem[int'(base) + o + i];
        if (we || mis) erd = 32'b0;
        if (we && !mis)
            for (int i = 0; i < nb; i++) ref_mem[int'(base) + o + i] = wd[8*i +: 8];
        rdat = 32'b0;

        @(negedge clk);
        if (is_if) begin
            if_req_valid = 1'b1; if_addr = a;
        end else begin
            d_req_valid = 1'b1; d_addr = a; d_we = we; d_size = sz; d_wdata = wd;
        end
        n = 0;
        #1;
        while (!(is_if ? if_req_ready : d_req_ready) && n < 20) begin
            @(negedge clk); #1; n++;
        end
        tests_run++;
        if (n >= 20) begin
            failed++;
            $display("FAIL %s accept: ready never seen, waited %0d cycles, required within 20", nm, n);
        end else begin
            got_req = {mem_req, mem_addr, mem_we, mem_be, mem_wdata};
            exp_req = mis ? 70'b0 : {1'b1, a[31:2], 2'b00, we, ebe, (we ? ewd : mem_wdata)};
            if (got_req !== exp_req) begin
                failed++;
                $display("FAIL %s mem_req: req/addr/we/be/wdata got %0b/%h/%0b/%h/%h required %0b/%h/%0b/%h/%h",
                         nm, mem_req, mem_addr, mem_we, mem_be, mem_wdata,
                         exp_req[69], exp_req[68:37], exp_req[36], exp_req[35:32], exp_req[31:0]);
            end
        end
        @(posedge clk); #1;
        if_req_valid = 1'b0;
        d_req_valid  = 1'b0;

        k = 0; got_v = 1'b0;
        while (!got_v && k < 20) begin
            @(negedge clk); #1; k++;
            got_v = is_if ? if_resp_valid : d_resp_valid;
        end
        tests_run++;
        if (!got_v) begin
            failed++;
            $display("FAIL %s resp: no response within %0d cycles", nm, k);
        end else begin
            rdat    = is_if ? if_resp_data : d_resp_data;
            got_rsp = {if_resp_valid, d_resp_valid, d_resp_err, rdat};
            exp_rsp = {is_if, !is_if, mis && !is_if, erd};
            if (got_rsp !== exp_rsp) begin
                failed++;
                $display("FAIL %s resp: if_v/d_v/err/data got %0b/%0b/%0b/%h required %0b/%0b/%0b/%h",
                         nm, got_rsp[34], got_rsp[33], got_rsp[32], got_rsp[31:0],
                         exp_rsp[34], exp_rsp[33], exp_rsp[32], exp_rsp[31:0]);
            end
            tests_run++;
            if (k !== (mis ? 1 : lat_fixed + 1)) begin
                failed++;
                $display("FAIL %s latency: response %0d cycles after request, required %0d",
                         nm, k, mis ? 1 : lat_fixed + 1);
            end
        end
    endtask

    task automatic test_reset();
        logic [109:0] outs;
        @(negedge clk);
        if_req_valid = 1'b1; if_addr = 32'h40;
        d_req_valid  = 1'b1; d_addr = 32'h80; d_we = 1'b0; d_size = 2'd2;
        for (int c = 0; c < 2; c++) begin
            #1;
            outs = {if_req_ready, d_req_ready, if_resp_valid, d_resp_valid, d_resp_err,
                    mem_req, mem_we, mem_be, mem_addr, mem_wdata, d_resp_data[8:0]};
            tests_run++;
            if (outs !== 110'b0) begin
                failed++;
                $display("FAIL reset_outputs cycle %0d: outputs %h required all zero", c, outs);
            end
            @(negedge clk);
        end
        reset = 1'b0;
        #1;
        tests_run++;
        if ({d_req_ready, if_req_ready, mem_req} !== 3'b101) begin
            failed++;
            $display("FAIL reset_first_grant: d_rdy/if_rdy/mem_req got %0b%0b%0b required 101",
                     d_req_ready, if_req_ready, mem_req);
        end
        @(posedge clk); #1;
        if_req_valid = 1'b0;
        d_req_valid  = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_fetch();
        logic [31:0] r;
        lat_fixed = 2;
        do_access(1'b1, 32'h100, 1'b0, 2'd2, 32'h0, "fetch_0x100", r);
        lat_fixed = 1;
    endtask

    task automatic test_byte_half();
        logic [31:0] r;
        do_access(1'b0, 32'h203, 1'b1, 2'd0, 32'h0000_00AB, "sb_0x203", r);
        {phys_mem[32'h203], phys_mem[32'h202], phys_mem[32'h201], phys_mem[32'h200]} = 32'h8001_0000;
        {ref_mem[32'h203],  ref_mem[32'h202],  ref_mem[32'h201],  ref_mem[32'h200]}  = 32'h8001_0000;
        do_access(1'b0, 32'h202, 1'b0, 2'd1, 32'h0, "lh_0x202", r);
        tests_run++;
        if (r !== 32'h0000_8001) begin
            failed++;
            $display("FAIL lh_value: d_resp_data %h required 00008001", r);
        end
    endtask

    task automatic test_starve();
        int n;
        bit exp_if;
        @(negedge clk);
        if_req_valid = 1'b1; if_addr = 32'h40;
        d_req_valid  = 1'b1; d_addr = 32'h80; d_we = 1'b0; d_size = 2'd2;
        for (int g = 0; g < 10; g++) begin
            n = 0;
            #1;
            while (!d_req_ready && !if_req_ready && n < 20) begin
                @(negedge clk); #1; n++;
            end
            exp_if = ((g + 1) % (STARVE_MAX + 1)) == 0;
            tests_run++;
            if (n >= 20 || if_req_ready !== exp_if || d_req_ready !== !exp_if) begin
                failed++;
                $display("FAIL starve grant %0d: if_rdy/d_rdy %0b/%0b required %0b/%0b (waited %0d)",
                         g, if_req_ready, d_req_ready, exp_if, !exp_if, n);
            end
            if (g < 9) @(negedge clk);
        end
        @(posedge clk); #1;
        if_req_valid = 1'b0;
        d_req_valid  = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset_in_wait();
        logic [31:0] r;
        int spurious, seen0;
        lat_fixed = 3;
        @(negedge clk);
        if_req_valid = 1'b1; if_addr = 32'h140;
        #1;
        tests_run++;
        if (if_req_ready !== 1'b1) begin
            failed++;
            $display("FAIL rst_wait accept: if_req_ready %0b required 1", if_req_ready);
        end
        @(posedge clk); #1;
        if_req_valid = 1'b0;
        seen0 = rvalid_seen;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        spurious = 0;
        repeat (6) begin
            @(negedge clk); #1;
            if (if_resp_valid || d_resp_valid) spurious++;
        end
        tests_run++;
        if (spurious !== 0 || rvalid_seen - seen0 !== 1) begin
            failed++;
            $display("FAIL rst_wait drop: resp pulses %0d required 0 (mem completions %0d required 1)",
                     spurious, rvalid_seen - seen0);
        end
        lat_fixed = 1;
        do_access(1'b0, 32'h144, 1'b0, 2'd2, 32'h0, "rst_wait_next", r);
    endtask

    task automatic test_misaligned_word();
        logic [31:0] r;
        do_access(1'b0, 32'h202, 1'b0, 2'd2, 32'h0, "lw_0x202", r);
    endtask

    task automatic test_random();
        logic [31:0] r;
        bit is_if;
        for (int t = 0; t < 40; t++) begin
            lat_fixed = $urandom_range(1, 3);
            is_if = ($urandom_range(0, 3) == 0);
            do_access(is_if, 32'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)),
                      2'($urandom_range(0, 3)), $urandom, "random", r);
        end
        lat_fixed = 1;
    endtask

    initial begin
        reset = 1'b1;
        if_req_valid = 1'b0; if_addr = 32'b0;
        d_req_valid = 1'b0; d_addr = 32'b0; d_we = 1'b0; d_size = 2'b0; d_wdata = 32'b0;
        for (int i = 0; i < 1024; i++) begin
            phys_mem[i] = 8'($urandom);
            ref_mem[i]  = phys_mem[i];
        end
        test_reset();
        test_fetch();
        test_byte_half();
        test_starve();
        test_reset_in_wait();
        test_misaligned_word();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
